// File: rtl/sram_word_ctrl_if.sv
// Request/response bus between the pipeline memory stage and sram_word_ctrl.
// master = requester (pipeline), slave = controller.
interface sram_word_ctrl_if;
  logic        w_en_in;
  logic        r_en_in;
  logic [31:0] address_in;
  logic [31:0] write_data_in;
  logic [31:0] read_data_out;
  logic        ready_out;

  modport master (
    output w_en_in, r_en_in, address_in, write_data_in,
    input  read_data_out, ready_out
  );

  modport slave (
    input  w_en_in, r_en_in, address_in, write_data_in,
    output read_data_out, ready_out
  );
endinterface

// File: rtl/sram_word_ctrl.sv
// Splits each 32-bit word access into two 16-bit accesses on a 256K x 16 async SRAM.
// Macro SRAM_BASE_OFFSET_EN: when defined, CPU byte address 1024 maps to SRAM word 0.
module sram_word_ctrl (
  input  logic             clk,
  input  logic             rst,
  sram_word_ctrl_if.slave  bus,
  inout  wire  [15:0]      sram_dq_out,
  output logic [17:0]      sram_addr_out,
  output logic             sram_ub_n_out,
  output logic             sram_lb_n_out,
  output logic             sram_ce_n_out,
  output logic             sram_oe_n_out,
  output logic             sram_we_n_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_LO = 3'd1,
    ACC_HI = 3'd2,
    WAIT1  = 3'd3,
    WAIT2  = 3'd4,
    WAIT3  = 3'd5,
    DONE   = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [16:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_wr_q, is_wr_d;
  logic [15:0] lo_q, lo_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] eff_addr;
  logic        req;
  logic        dq_oe;
  logic [15:0] dq_val;
  logic        unused_addr_bits;

`ifdef SRAM_BASE_OFFSET_EN
  assign eff_addr = bus.address_in - 32'd1024;
`else
  assign eff_addr = bus.address_in;
`endif

  // Only the word index reaches the SRAM; byte offset and bits above 18 alias.
  assign unused_addr_bits = ^{eff_addr[31:19], eff_addr[1:0]};
  assign req              = bus.w_en_in | bus.r_en_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = ACC_LO;
      ACC_LO:  state_d = ACC_HI;
      ACC_HI:  state_d = WAIT1;
      WAIT1:   state_d = WAIT2;
      WAIT2:   state_d = WAIT3;
      WAIT3:   state_d = DONE;
      // A request still held from the finished access must not restart it.
      DONE:    if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    word_d  = word_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          word_d  = eff_addr[18:2];
          wdata_d = bus.write_data_in;
          is_wr_d = bus.w_en_in;
        end
      end
      ACC_LO: if (!is_wr_q) lo_d = sram_dq_out;
      ACC_HI: if (!is_wr_q) rdata_d = {sram_dq_out, lo_q};
      default: ;
    endcase
  end

  always_comb begin
    sram_addr_out = '0;
    sram_we_n_out = 1'b1;
    dq_oe         = 1'b0;
    dq_val        = '0;
    bus.ready_out = 1'b0;
    case (state_q)
      IDLE: bus.ready_out = !req;
      ACC_LO: begin
        sram_addr_out = {word_q, 1'b0};
        sram_we_n_out = !is_wr_q;
        dq_oe         = is_wr_q;
        dq_val        = wdata_q[15:0];
      end
      ACC_HI: begin
        sram_addr_out = {word_q, 1'b1};
        sram_we_n_out = !is_wr_q;
        dq_oe         = is_wr_q;
        dq_val        = wdata_q[31:16];
      end
      DONE:    bus.ready_out = 1'b1;
      default: ;
    endcase
    // Report idle while held in reset even if a requester keeps its enables up.
    if (!rst) bus.ready_out = 1'b1;
  end

  assign sram_dq_out       = dq_oe ? dq_val : 16'bz;
  assign bus.read_data_out = rdata_q;
  assign sram_ub_n_out     = 1'b0;
  assign sram_lb_n_out     = 1'b0;
  assign sram_ce_n_out     = 1'b0;
  assign sram_oe_n_out     = 1'b0;

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Scoreboard bench for sram_word_ctrl: stimulus pushes expected completions, a negedge
// monitor pops them when ready_out rises; a 256K x 16 async SRAM model sits on the bus.
module tb_sram_word_ctrl;

`ifdef SRAM_BASE_OFFSET_EN
  localparam logic [31:0] OFF = 32'd1024;
`else
  localparam logic [31:0] OFF = 32'd0;
`endif

  typedef struct {
    bit          wr;
    logic [16:0] word;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n, sram_we_n;

  sram_word_ctrl_if bus_if();

  sram_word_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus_if.slave),
    .sram_dq_out   (sram_dq),
    .sram_addr_out (sram_addr),
    .sram_ub_n_out (sram_ub_n),
    .sram_lb_n_out (sram_lb_n),
    .sram_ce_n_out (sram_ce_n),
    .sram_oe_n_out (sram_oe_n),
    .sram_we_n_out (sram_we_n)
  );

  always #5 clk = ~clk;

  // Async SRAM model: drives the bus whenever not being written, writes at the edge.
  logic [15:0] sram_mem [0:262143];
  assign sram_dq = sram_we_n ? sram_mem[sram_addr] : 16'hzzzz;
  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;
  end

  int          total = 0;
  int          bad   = 0;
  exp_t        exp_q[$];
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, want);
    end
  endtask

  // Reference: word index from plain byte-address arithmetic on the rebased address.
  function automatic logic [16:0] word_of(input logic [31:0] addr);
    logic [31:0] eff;
    eff = addr - OFF;
    return 17'((eff / 4) % 131072);
  endfunction

  // Starts at posedge+1, returns at posedge+1 with the controller back in IDLE.
  task automatic do_txn(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] data, input int hold);
    exp_t e;
    bit   seen;
    e.word  = word_of(addr);
    e.wr    = wr;
    e.wdata = data;
    if (wr) begin
      ref_mem[int'(e.word)] = data;
      e.rdata = last_rd;
    end else begin
      e.rdata = ref_mem.exists(int'(e.word)) ? ref_mem[int'(e.word)] : 32'h0;
      last_rd = e.rdata;
    end
    exp_q.push_back(e);
    bus_if.w_en_in       = wr;
    bus_if.r_en_in       = rd;
    bus_if.address_in    = addr;
    bus_if.write_data_in = data;
    #1;
    chk("ready_fall", {31'd0, bus_if.ready_out}, 32'd0);
    @(posedge clk);
    #1;
    bus_if.address_in    = $urandom;
    bus_if.write_data_in = $urandom;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (bus_if.ready_out) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got=ready_low expected=ready_high word=%h", e.word);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_ready", {31'd0, bus_if.ready_out}, 32'd1);
    end
    @(posedge clk);
    #1;
    bus_if.w_en_in = 1'b0;
    bus_if.r_en_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: a rising ready_out (out of reset) marks one completed access.
  initial begin
    int   low_cnt;
    bit   prev_ready;
    exp_t e;
    low_cnt    = 0;
    prev_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        low_cnt    = 0;
        prev_ready = 1'b1;
      end else begin
        if (!bus_if.ready_out) begin
          low_cnt++;
        end else if (!prev_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got=completion expected=none");
          end else begin
            e = exp_q.pop_front();
            $display("done wr=%0d word=%h rd=%h lat=%0d", e.wr, e.word, bus_if.read_data_out, low_cnt);
            chk("read_data", bus_if.read_data_out, e.rdata);
            chk("busy_cycles", low_cnt, 32'd6);
            if (e.wr) begin
              chk("sram_lo", {16'd0, sram_mem[{e.word, 1'b0}]}, {16'd0, e.wdata[15:0]});
              chk("sram_hi", {16'd0, sram_mem[{e.word, 1'b1}]}, {16'd0, e.wdata[31:16]});
            end
          end
          low_cnt = 0;
        end
        prev_ready = bus_if.ready_out;
      end
    end
  end

  initial begin
    logic [16:0] w;
    logic [31:0] a;
    int          op;
    rst                  = 1'b0;
    bus_if.w_en_in       = 1'b0;
    bus_if.r_en_in       = 1'b0;
    bus_if.address_in    = '0;
    bus_if.write_data_in = '0;
    last_rd              = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, bus_if.ready_out}, 32'd1);
    chk("rst_rdata", bus_if.read_data_out, 32'd0);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_dq_undriven", {16'd0, sram_dq}, {16'd0, sram_mem[sram_addr]});
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    do_txn(1'b1, 1'b0, OFF + 32'd0, 32'h3344_1122, 0);
    chk("wr0_mem0", {16'd0, sram_mem[0]}, 32'h1122);
    chk("wr0_mem1", {16'd0, sram_mem[1]}, 32'h3344);
    do_txn(1'b0, 1'b1, OFF + 32'd0, $urandom, 0);
    chk("rd0_value", bus_if.read_data_out, 32'h3344_1122);
    do_txn(1'b0, 1'b1, OFF + 32'd0, $urandom, 4);

    do_txn(1'b1, 1'b1, OFF + 32'd8, 32'hDEAD_BEEF, 0);
    chk("both_mem4", {16'd0, sram_mem[4]}, 32'hBEEF);
    chk("both_mem5", {16'd0, sram_mem[5]}, 32'hDEAD);
    chk("both_rdata_kept", bus_if.read_data_out, 32'h3344_1122);

    do_txn(1'b1, 1'b0, OFF + 32'd4, 32'hA5A5_0F0F, 0);
    chk("wr4_mem2", {16'd0, sram_mem[2]}, 32'h0F0F);
    chk("wr4_mem3", {16'd0, sram_mem[3]}, 32'hA5A5);

    // Top word, with high address bits and byte offset that must be ignored.
    do_txn(1'b1, 1'b0, OFF + 32'h8007_FFFC, 32'h1357_9BDF, 0);
    chk("top_mem_lo", {16'd0, sram_mem[18'h3FFFE]}, 32'h9BDF);
    chk("top_mem_hi", {16'd0, sram_mem[18'h3FFFF]}, 32'h1357);
    do_txn(1'b0, 1'b1, OFF + 32'h0007_FFFF, $urandom, 1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        8:       w = 17'h1FFFF;
        9:       w = 17'($urandom);
        default: w = 17'($urandom_range(0, 7));
      endcase
      a  = OFF + {13'd0, w, 2'b00} + $urandom_range(0, 3) + ($urandom_range(0, 3) << 19);
      op = $urandom_range(0, 2);
      do_txn(op != 1, op != 0, a, $urandom, $urandom_range(0, 2));
    end

    // Reset while the controller sits in WAIT2 of a read.
    bus_if.r_en_in    = 1'b1;
    bus_if.address_in = OFF + 32'd8;
    repeat (4) @(posedge clk);
    #1;
    rst            = 1'b0;
    bus_if.r_en_in = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, bus_if.ready_out}, 32'd1);
    chk("midrst_rdata", bus_if.read_data_out, 32'd0);
    chk("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("midrst_addr", {14'd0, sram_addr}, 32'd0);
    last_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_txn(1'b0, 1'b1, OFF + 32'd8, $urandom, 0);

    repeat (3) @(posedge clk);
    chk("pending_expectations", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
